// File: rtl/dcache_inval_seq.sv
// dcache_inval_seq: sweeps every set index and clears the per-way valid/dirty bits, stalling the cache meanwhile
module dcache_inval_seq #(
  parameter int unsigned NUM_WORDS   = 256,
  parameter int unsigned SET_ASSOC   = 8,
  parameter int unsigned BYTE_OFFSET = 4,
  parameter int unsigned INDEX_WIDTH = 12
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     init_ni,
  input  logic                     inval_req_i,
  output logic                     inval_ack_o,
  output logic                     busy_o,
  output logic                     stall_o,
  output logic [SET_ASSOC-1:0]     req_o,
  output logic                     we_o,
  output logic [INDEX_WIDTH-1:0]   addr_o,
  output logic [SET_ASSOC*8-1:0]   be_vldrty_o,
  output logic                     valid_o,
  output logic                     dirty_o,
  input  logic                     gnt_i
);
  localparam int unsigned CW = $clog2(NUM_WORDS);
  typedef enum logic [1:0] {START, SWEEP, ACK, IDLE} state_e;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          from_req_q, from_req_d;
  // state, index counter and request-origin flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= START;
      cnt_q      <= '0;
      from_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      from_req_q <= from_req_d;
    end
  end
  // next-state and SRAM write decode; an init pulse restarts the sweep ahead of any grant
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    from_req_d  = from_req_q;
    req_o       = '0;
    we_o        = 1'b0;
    be_vldrty_o = '0;
    inval_ack_o = 1'b0;
    case (state_q)
      START: state_d = SWEEP;
      SWEEP: begin
        req_o       = '1;
        we_o        = 1'b1;
        be_vldrty_o = {SET_ASSOC{8'h03}};
        if (!init_ni) begin
          cnt_d = '0;
        end else if (gnt_i) begin
          if (cnt_q == CW'(NUM_WORDS - 1)) begin
            cnt_d   = '0;
            state_d = from_req_q ? ACK : IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ACK: begin
        inval_ack_o = 1'b1;
        from_req_d  = 1'b0;
        state_d     = IDLE;
      end
      IDLE: begin
        if (!init_ni || inval_req_i) begin
          state_d    = SWEEP;
          cnt_d      = '0;
          from_req_d = init_ni;
        end
      end
    endcase
  end
  assign addr_o  = {cnt_q, {BYTE_OFFSET{1'b0}}};
  assign busy_o  = (state_q != IDLE);
  assign stall_o = busy_o;
  assign valid_o = 1'b0;
  assign dirty_o = 1'b0;
endmodule
